// File: rtl/kuuga_bram_master_if.sv
// Core-side request/response port of the BRAM master bridge.
// The core drives requests and consumes responses through the master modport.
interface kuuga_bram_master_if;
   logic        req_i;
   logic        gnt_o;
   logic [31:0] addr_i;
   logic        we_i;
   logic [3:0]  be_i;
   logic [31:0] wdata_i;
   logic        rvalid_o;
   logic        rready_i;
   logic [31:0] rdata_o;
   logic        err_o;

   modport master (
      output req_i, addr_i, we_i, be_i, wdata_i, rready_i,
      input  gnt_o, rvalid_o, rdata_o, err_o
   );

   modport slave (
      input  req_i, addr_i, we_i, be_i, wdata_i, rready_i,
      output gnt_o, rvalid_o, rdata_o, err_o
   );
endinterface

// File: rtl/kuuga_bram_master.sv
// Bridge from a req/gnt/rvalid core port to one single-port BRAM.
// Tracks the fixed read latency and returns in-order responses via a FIFO.
module kuuga_bram_master #(
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned ADDR_WIDTH   = 16,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   kuuga_bram_master_if.slave    bus,
   output logic [15:0]           err_count_o,
   output logic                  bram_clk_o,
   output logic                  bram_rst_o,
   output logic                  bram_en_o,
   output logic [3:0]            bram_we_o,
   output logic [ADDR_WIDTH-1:0] bram_addr_o,
   output logic [31:0]           bram_wrdata_o,
   input  logic [31:0]           bram_rddata_i
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 1);

   logic                    in_range;
   logic                    accept;
   logic [READ_LATENCY-1:0] pv;
   logic [READ_LATENCY-1:0] pw;
   logic [READ_LATENCY-1:0] pe;
   logic [31:0]             fifo_data [FIFO_DEPTH];
   logic                    fifo_err  [FIFO_DEPTH];
   logic [PW-1:0]           wr_ptr;
   logic [PW-1:0]           rd_ptr;
   logic [CW-1:0]           count;
   logic [CW-1:0]           inflight;
   logic                    push;
   logic                    pop;
   logic [31:0]             push_data;

   assign bram_clk_o = clk;
   assign bram_rst_o = reset;

   assign in_range = bus.addr_i[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH];

   // Credit check uses registered occupancy only, so no path from rready_i.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++)
         inflight = inflight + CW'(pv[i]);
   end

   assign bus.gnt_o = !reset && ((inflight + count) < CW'(FIFO_DEPTH));
   assign accept    = bus.req_i && bus.gnt_o;

   assign bram_en_o     = accept && in_range;
   assign bram_we_o     = (accept && in_range && bus.we_i) ? bus.be_i : 4'b0;
   assign bram_addr_o   = bus.addr_i[ADDR_WIDTH-1:0];
   assign bram_wrdata_o = bus.wdata_i;

   assign push      = pv[READ_LATENCY-1];
   assign pop       = (count != '0) && bus.rready_i;
   assign push_data = (pw[READ_LATENCY-1] || pe[READ_LATENCY-1]) ?
                      32'h0 : bram_rddata_i;

   assign bus.rvalid_o = count != '0;
   assign bus.rdata_o  = bus.rvalid_o ? fifo_data[rd_ptr] : 32'h0;
   assign bus.err_o    = bus.rvalid_o ? fifo_err[rd_ptr] : 1'b0;

   // Latency pipeline, FIFO pointers/occupancy and error counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         pv          <= '0;
         pw          <= '0;
         pe          <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         err_count_o <= '0;
      end else begin
         pv[0] <= accept;
         pw[0] <= bus.we_i;
         pe[0] <= !in_range;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pv[i] <= pv[i-1];
            pw[i] <= pw[i-1];
            pe[i] <= pe[i-1];
         end
         if (push)
            wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
         if (accept && !in_range && err_count_o != 16'hFFFF)
            err_count_o <= err_count_o + 16'd1;
      end
   end

   // Response storage; contents are masked by the empty flag on output.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= push_data;
         fifo_err[wr_ptr]  <= pe[READ_LATENCY-1];
      end
   end

endmodule

// File: tb/tb_kuuga_bram_master.sv
// Self-checking bench for kuuga_bram_master with a BRAM model and
// a transaction-level scoreboard of expected responses.
module tb_kuuga_bram_master;

   typedef struct {
      logic [31:0] d;
      logic        e;
   } rsp_t;

   logic        clk;
   logic        reset;
   logic [15:0] err_count_o;
   logic        bram_clk_o;
   logic        bram_rst_o;
   logic        bram_en_o;
   logic [3:0]  bram_we_o;
   logic [15:0] bram_addr_o;
   logic [31:0] bram_wrdata_o;
   logic [31:0] bram_rddata_i;

   kuuga_bram_master_if bus ();

   kuuga_bram_master dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .err_count_o   (err_count_o),
      .bram_clk_o    (bram_clk_o),
      .bram_rst_o    (bram_rst_o),
      .bram_en_o     (bram_en_o),
      .bram_we_o     (bram_we_o),
      .bram_addr_o   (bram_addr_o),
      .bram_wrdata_o (bram_wrdata_o),
      .bram_rddata_i (bram_rddata_i)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] bmem [256];
   logic [31:0] smem [256];
   logic [31:0] rd_p0, rd_p1;
   rsp_t        exp_q [$];
   int          m_err = 0;
   int          cyc = 0;
   int          rv_cnt = 0;
   int          first_rv = -1;
   int          last_rv = -1;
   logic [31:0] last_rdata = '0;
   logic        last_err = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // BRAM model: byte-write on en, read data valid two cycles after en.
   always @(posedge clk) begin
      if (bram_en_o) begin
         rd_p0 <= bmem[bram_addr_o[9:2]];
         for (int b = 0; b < 4; b++)
            if (bram_we_o[b])
               bmem[bram_addr_o[9:2]][8*b +: 8] <= bram_wrdata_o[8*b +: 8];
      end
      rd_p1 <= rd_p0;
   end
   assign bram_rddata_i = rd_p1;

   // Scoreboard: expected responses generated at accept, checked at pop.
   always @(negedge clk) begin : mon
      rsp_t r;
      logic acc, inr;
      cyc++;
      acc = bus.req_i && bus.gnt_o;
      inr = bus.addr_i[31:16] == 16'h0;
      if (reset) begin
         exp_q.delete();
         m_err = 0;
         chk("rst_gnt", bus.gnt_o, 0);
         chk("rst_en", bram_en_o, 0);
      end else begin
         chk("err_count", err_count_o, m_err);
         chk("bram_en", bram_en_o, acc && inr);
         chk("bram_we", bram_we_o,
             (acc && inr && bus.we_i) ? bus.be_i : 4'b0);
         chk("bram_addr", bram_addr_o, bus.addr_i[15:0]);
         if (bus.rvalid_o) begin
            rv_cnt++;
            if (first_rv < 0) first_rv = cyc;
            last_rv = cyc;
         end
         if (bus.rvalid_o && bus.rready_i) begin
            if (exp_q.size() == 0) begin
               chk("spurious_rsp", 1, 0);
            end else begin
               r = exp_q.pop_front();
               chk("rsp_data", bus.rdata_o, r.d);
               chk("rsp_err", bus.err_o, r.e);
            end
            last_rdata = bus.rdata_o;
            last_err   = bus.err_o;
         end
         if (acc) begin
            if (!inr) begin
               r.d = 0; r.e = 1;
               if (m_err < 16'hFFFF) m_err++;
            end else if (bus.we_i) begin
               for (int b = 0; b < 4; b++)
                  if (bus.be_i[b])
                     smem[bus.addr_i[9:2]][8*b +: 8] = bus.wdata_i[8*b +: 8];
               r.d = 0; r.e = 0;
            end else begin
               r.d = smem[bus.addr_i[9:2]]; r.e = 0;
            end
            exp_q.push_back(r);
         end
         assert (exp_q.size() <= 4) else begin
            n_fail++;
            $error("FAIL overflow: observed %0d expected <= 4", exp_q.size());
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic drive(input logic rq, input logic [31:0] a,
                        input logic w, input logic [3:0] be,
                        input logic [31:0] wd);
      bus.req_i = rq; bus.addr_i = a; bus.we_i = w;
      bus.be_i = be; bus.wdata_i = wd;
   endtask

   task automatic idle();
      drive(0, 32'h0, 0, 4'h0, 32'h0);
   endtask

   task automatic wait_drain();
      bit done = 0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk); #1;
         if (exp_q.size() == 0 && !bus.rvalid_o) done = 1;
      end
      if (!done) chk("drain_timeout", 0, 1);
   endtask

   initial begin : stim
      int grants, grants2;
      logic [31:0] a;
      #2000000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int grants, grants2;
      logic last_gnt;
      logic [31:0] a;
      for (int i = 0; i < 256; i++) begin
         bmem[i] = $urandom;
         smem[i] = bmem[i];
      end
      bmem[4] = 32'hDEADBEEF; smem[4] = 32'hDEADBEEF;
      bmem[8] = 32'h11223344; smem[8] = 32'h11223344;
      reset = 1'b1;
      bus.rready_i = 1'b1;
      idle();
      @(negedge clk);
      @(negedge clk);
      chk("rst_bram_rst", bram_rst_o, 1);
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("init_rvalid", bus.rvalid_o, 0);
      chk("init_rdata", bus.rdata_o, 0);
      chk("init_err", bus.err_o, 0);
      chk("init_errcnt", err_count_o, 0);
      chk("init_gnt", bus.gnt_o, 1);

      // single read with latency check
      tick();
      drive(1, 32'h10, 0, 4'h0, 32'h0);
      @(negedge clk);
      chk("rd_gnt", bus.gnt_o, 1);
      chk("rd_en", bram_en_o, 1);
      chk("rd_addr", bram_addr_o, 16'h0010);
      tick(); idle();
      @(negedge clk); chk("rd_lat1", bus.rvalid_o, 0);
      tick();
      @(negedge clk); chk("rd_lat2", bus.rvalid_o, 0);
      tick();
      @(negedge clk);
      chk("rd_lat3", bus.rvalid_o, 1);
      chk("rd_data", bus.rdata_o, 32'hDEADBEEF);
      chk("rd_err", bus.err_o, 0);

      // byte write then read back
      tick();
      drive(1, 32'h20, 1, 4'b0010, 32'h0000AB00);
      @(negedge clk);
      chk("wr_we", bram_we_o, 4'b0010);
      chk("wr_wdata", bram_wrdata_o, 32'h0000AB00);
      tick();
      drive(1, 32'h20, 0, 4'h0, 32'h0);
      tick(); idle();
      wait_drain();
      chk("wr_readback", last_rdata, 32'h1122AB44);

      // back-to-back reads
      tick();
      rv_cnt = 0; first_rv = -1; last_rv = -1;
      for (int i = 0; i < 8; i++) begin
         drive(1, 32'(i * 4), 0, 4'h0, 32'h0);
         @(negedge clk);
         chk("b2b_gnt", bus.gnt_o, 1);
         tick();
      end
      idle();
      wait_drain();
      chk("b2b_count", rv_cnt, 8);
      chk("b2b_consec", last_rv - first_rv, 7);

      // backpressure
      tick();
      bus.rready_i = 1'b0;
      grants = 0;
      last_gnt = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(1, 32'h40, 0, 4'h0, 32'h0);
         @(negedge clk);
         if (bus.gnt_o) grants++;
         last_gnt = bus.gnt_o;
         tick();
      end
      chk("bp_grants", grants, 4);
      chk("bp_gnt_low", last_gnt, 0);
      bus.rready_i = 1'b1;
      grants2 = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.gnt_o) grants2++;
         tick();
      end
      idle();
      chk("bp_resume", grants2 != 0, 1);
      wait_drain();

      // out-of-range request
      tick();
      drive(1, 32'h0001_0000, 0, 4'h0, 32'h0);
      @(negedge clk);
      chk("oor_gnt", bus.gnt_o, 1);
      chk("oor_en", bram_en_o, 0);
      tick(); idle();
      wait_drain();
      chk("oor_err", last_err, 1);
      chk("oor_rdata", last_rdata, 0);
      chk("oor_errcnt", err_count_o, 1);

      // reset with two reads in flight
      tick();
      drive(1, 32'h10, 0, 4'h0, 32'h0);
      tick();
      drive(1, 32'h14, 0, 4'h0, 32'h0);
      tick();
      drive(1, 32'h18, 0, 4'h0, 32'h0);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_gnt", bus.gnt_o, 0);
      chk("mid_rst_en", bram_en_o, 0);
      chk("mid_rst_we", bram_we_o, 0);
      tick();
      reset = 1'b0;
      idle();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("mid_rst_norsp", bus.rvalid_o, 0);
         tick();
      end
      chk("mid_rst_errcnt", err_count_o, 0);
      drive(1, 32'h10, 0, 4'h0, 32'h0);
      tick(); idle();
      wait_drain();
      chk("post_rst_rd", last_rdata, 32'hDEADBEEF);

      // randomized traffic
      tick();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0)
            a = {16'($urandom_range(1, 16'hFFFF)), 16'($urandom)};
         else
            a = 32'($urandom_range(0, 255)) << 2;
         drive($urandom_range(0, 3) != 0, a, 1'($urandom),
               4'($urandom), $urandom);
         bus.rready_i = $urandom_range(0, 3) != 0;
         tick();
      end
      idle();
      bus.rready_i = 1'b1;
      wait_drain();
      chk("rand_errcnt", err_count_o, m_err);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/kuuga_bram_master.md
Name: kuuga_bram_master

Overview:
- Initiator-side bridge between a core-style LSU/fetch port (req/gnt/rvalid) and one single-port BRAM controller port (byte address, en, we, wrdata, rddata).
- Issues BRAM accesses, tracks the fixed BRAM read latency, and returns exactly one in-order response per granted request.
- Response FIFO with credit-based grant absorbs response backpressure.
- One instance sits in front of the instruction memory, one in front of the data memory.

Parameters:
- READ_LATENCY, 2, BRAM read latency in cycles from en to valid rddata; legal range 1..4.
- ADDR_WIDTH, 16, width of the BRAM byte address.
- BASE_ADDR, 32'h0000_0000, region base; must be aligned to 2^ADDR_WIDTH.
- FIFO_DEPTH, 4, response FIFO entries; must be >= READ_LATENCY+2 for full throughput.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- req_i  in  1  request valid.
- gnt_o  out  1  request accepted this cycle when req_i && gnt_o.
- addr_i  in  32  byte address.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  4  byte enables for writes.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid.
- rready_i  in  1  response consumed when rvalid_o && rready_i.
- rdata_o  out  32  read data; 0 for writes and errors.
- err_o  out  1  response belongs to an out-of-range request.
- err_count_o  out  16  saturating count of out-of-range requests.
- bram_clk_o  out  1  equals clk.
- bram_rst_o  out  1  equals reset.
- bram_en_o  out  1  BRAM enable.
- bram_we_o  out  4  BRAM byte write enables.
- bram_addr_o  out  ADDR_WIDTH  BRAM byte address.
- bram_wrdata_o  out  32  BRAM write data.
- bram_rddata_i  in  32  BRAM read data.

Behaviour:
- Accept (A) = req_i && gnt_o in the same cycle.
- gnt_o = !reset && (inflight + fifo_count) < FIFO_DEPTH.
  - inflight = valid entries in the latency pipeline.
  - Counters are registered; the same-cycle pop is not credited. This makes gnt_o conservative but free of combinational loops from rready_i.
- In range = addr_i[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH].
- BRAM outputs are combinational in the accept cycle:
  - bram_en_o = A && in_range.
  - bram_we_o = (A && in_range && we_i) ? be_i : 4'b0.
  - bram_addr_o = addr_i[ADDR_WIDTH-1:0], passed unaltered; the word shift happens at the memory.
  - bram_wrdata_o = wdata_i.
  - When no access is issued, bram_addr_o and bram_wrdata_o hold addr_i and wdata_i, and en/we are 0.
- Latency pipeline:
  - READ_LATENCY stages of {valid, is_write, err}; stage 0 is loaded with {A, we_i, !in_range}.
  - When the last stage is valid, push one FIFO entry: rdata = (is_write || err) ? 0 : bram_rddata_i, plus err.
- FIFO:
  - Show-ahead, registered; rvalid_o = !empty, with rdata_o and err_o taken from the head entry.
  - Pop on rvalid_o && rready_i.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Overflow cannot occur by construction; the bench asserts this.
- Latency: accept in cycle T → rvalid_o high in cycle T+READ_LATENCY+1, i.e. T+3 at default, when the FIFO was empty.
- Throughput: 1 response/cycle sustained while rready_i = 1 and FIFO_DEPTH >= READ_LATENCY+2.
- Writes and errors occupy a pipeline slot and return a response, so ordering is strict FIFO across all request types.
- Out-of-range requests:
  - No BRAM access is issued.
  - err_o = 1 on that response.
  - err_count_o increments on accept and saturates at 16'hFFFF.
- Reset, applied in any cycle:
  - Next cycle: pipeline valids 0, FIFO empty, counters 0, err_count_o 0.
  - Outputs: rvalid_o 0, rdata_o 0, err_o 0.
  - While reset = 1: gnt_o 0, bram_en_o 0, bram_we_o 0.
  - In-flight responses are discarded.
  - bram_rst_o follows reset combinationally.

Test Plan:
- Read: mem[0x10] = 32'hDEADBEEF; req addr 32'h10 at T → bram_en_o = 1 and bram_addr_o = 16'h0010 at T; rvalid_o at T+3 with rdata_o = 32'hDEADBEEF, err_o = 0.
- Byte write then read: write addr 0x20, be 4'b0010, wdata 32'h0000AB00 over 32'h11223344 → bram_we_o = 4'b0010; write response rdata_o 0; subsequent read returns 32'h1122AB44.
- Back-to-back: 8 reads to 0x0..0x1C with rready_i = 1 → gnt_o high all 8 cycles; 8 consecutive rvalid_o in address order.
- Backpressure: rready_i = 0 with req_i held → exactly 4 grants, then gnt_o = 0; after rready_i = 1, 4 in-order responses, then grants resume.
- Out of range: BASE_ADDR = 0, req addr 32'h0001_0000 → bram_en_o stays 0; response err_o = 1, rdata_o = 0; err_count_o = 1.
- Reset mid-flight: reset 1 cycle after 2 reads are accepted → no rvalid_o afterwards; gnt_o = 0 during reset; err_count_o = 0; a new read after reset completes normally.
